// File: rtl/aleb_seq_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// aleb_seq_cmp_ctrl
//
// Multi-cycle sequencer for an N-bit unsigned A<=B / A<B compare. One
// external 2-bit ripple slice (LE = maj(~A1, B1, maj(~A0, B0, CI))) is reused
// for WIDTH/2 cycles, LSB pair first. The slice's LE output becomes the carry
// for the next pair, so the MSB pair is examined last and dominates.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   IN_VALID   request valid
//   IN_READY   block can accept a request (high only in IDLE)
//   IN_A/IN_B  unsigned operands, WIDTH bits
//   IN_LT      1 = strict A<B, 0 = A<=B
//   OUT_VALID  result valid, held until OUT_READY
//   OUT_READY  consumer accepts result
//   RESULT     compare result
//   SA0/SA1    slice A bits (driven only in RUN, 0 otherwise)
//   SB0/SB1    slice B bits (driven only in RUN, 0 otherwise)
//   SCI        slice carry-in (driven only in RUN, 0 otherwise)
//   SLE        slice LE output, sampled only in RUN
//
// Timing: accept at edge T, OUT_VALID after edge T+N, earliest re-accept at
// edge T+N+2 (one compare per N+2 cycles when the consumer never stalls).
// ---------------------------------------------------------------------------
module aleb_seq_cmp_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic             IN_LT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             RESULT,
    output logic             SA0,
    output logic             SA1,
    output logic             SB0,
    output logic             SB1,
    output logic             SCI,
    input  logic             SLE
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned CNTW = $clog2(N) + 1;

    // Reject odd or out-of-range widths at elaboration.
    if (((WIDTH % 2) != 0) || (WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
        $error("aleb_seq_cmp_ctrl: WIDTH must be even and in 2..64");
    end

    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNTW-1:0]  step_cnt;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic             carry;
    logic             result_q;
    logic             out_valid_q;
    logic             in_ready_q;

    // Sequencer: state, operand shifters, running carry and all outputs.
    // The carry is cleared when RUN ends (its final value moves to result_q),
    // and the shifters zero-fill to empty by the end of RUN, so the slice
    // drive bits read straight from registers and are 0 outside RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            step_cnt    <= '0;
            shift_a     <= '0;
            shift_b     <= '0;
            carry       <= 1'b0;
            result_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID && in_ready_q) begin
                        shift_a    <= IN_A;
                        shift_b    <= IN_B;
                        carry      <= ~IN_LT;
                        step_cnt   <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    shift_a  <= shift_a >> 2;
                    shift_b  <= shift_b >> 2;
                    step_cnt <= step_cnt + CNTW'(1);
                    if (step_cnt == LAST_STEP) begin
                        // Final pair: its LE is the answer.
                        result_q    <= SLE;
                        carry       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        carry <= SLE;
                    end
                end

                DONE: begin
                    if (OUT_READY) begin
                        result_q    <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    step_cnt    <= '0;
                    shift_a     <= '0;
                    shift_b     <= '0;
                    carry       <= 1'b0;
                    result_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign SA0       = shift_a[0];
    assign SA1       = shift_a[1];
    assign SB0       = shift_b[0];
    assign SB1       = shift_b[1];
    assign SCI       = carry;

endmodule

// File: tb/tb_aleb_seq_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aleb_seq_cmp_ctrl
//
// Scoreboarded bench for aleb_seq_cmp_ctrl at WIDTH=8 with a behavioural
// 2-bit ripple slice. Expected results are queued at accept time and a
// monitor pops one per OUT_VALID&OUT_READY handshake.
// ---------------------------------------------------------------------------
module tb_aleb_seq_cmp_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;

    logic             CLK       = 1'b0;
    logic             RST       = 1'b1;
    logic             IN_VALID  = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A      = '0;
    logic [WIDTH-1:0] IN_B      = '0;
    logic             IN_LT     = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b1;
    logic             RESULT;
    logic             SA0, SA1, SB0, SB1, SCI;
    logic             SLE;

    int checks = 0;
    int fails  = 0;
    bit sb[$];
    bit rand_stall = 1'b0;

    aleb_seq_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_LT     (IN_LT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .SA0       (SA0),
        .SA1       (SA1),
        .SB0       (SB0),
        .SB1       (SB1),
        .SCI       (SCI),
        .SLE       (SLE)
    );

    always #5 CLK = ~CLK;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Behavioural ripple slice.
    assign SLE = maj(~SA1, SB1, maj(~SA0, SB0, SCI));

    // Expected carry entering pair k: compare of the k low pairs only.
    function automatic logic ref_carry(input logic [7:0] a, input logic [7:0] b,
                                       input logic lt, input int k);
        logic [7:0] m;
        logic [7:0] al;
        logic [7:0] bl;
        m  = 8'((16'd1 << (2 * k)) - 16'd1);
        al = a & m;
        bl = b & m;
        return lt ? (al < bl) : (al <= bl);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request; returns #1 after the accept edge (or, with seq set,
    // #1 after the edge that raises OUT_VALID, having checked every RUN step).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic lt,
                         input bit exp, input bit seq);
        int n;
        IN_A     = a;
        IN_B     = b;
        IN_LT    = lt;
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 300) begin
            wait_cycle();
            n++;
        end
        if (!IN_READY) begin
            chk("accept_timeout", 64'(IN_READY), 64'(1));
            IN_VALID = 1'b0;
            return;
        end
        sb.push_back(exp);
        wait_cycle();
        IN_VALID = 1'b0;
        if (seq) begin
            for (int k = 0; k < int'(N); k++) begin
                chk("run_sa_pair", 64'({SA1, SA0}), 64'(a[2*k +: 2]));
                chk("run_sb_pair", 64'({SB1, SB0}), 64'(b[2*k +: 2]));
                chk("run_sci", 64'(SCI), 64'(ref_carry(a, b, lt, k)));
                chk("run_out_valid_low", 64'(OUT_VALID), 64'(0));
                chk("run_in_ready_low", 64'(IN_READY), 64'(0));
                wait_cycle();
            end
            chk("latency_out_valid", 64'(OUT_VALID), 64'(1));
            chk("done_slice_zero", 64'({SA1, SA0, SB1, SB0, SCI}), 64'(0));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            wait_cycle();
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rl;
        int         n;

        // Result monitor: one pop per handshake, sampled on the falling edge.
        fork
            forever begin
                @(negedge CLK);
                if (!RST && OUT_VALID && OUT_READY) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(OUT_VALID), 64'(0));
                    end else begin
                        bit e;
                        e = sb.pop_front();
                        chk("result", 64'(RESULT), 64'(e));
                    end
                end
            end
            forever begin
                @(posedge CLK);
                #1;
                if (rand_stall) OUT_READY = ($urandom_range(0, 3) != 0);
            end
        join_none

        // Reset state.
        repeat (3) wait_cycle();
        chk("reset_in_ready", 64'(IN_READY), 64'(1));
        chk("reset_out_valid", 64'(OUT_VALID), 64'(0));
        chk("reset_result", 64'(RESULT), 64'(0));
        chk("reset_slice", 64'({SA1, SA0, SB1, SB0, SCI}), 64'(0));
        RST = 1'b0;
        wait_cycle();

        // Equal operands, then extremes, then MSB dominance.
        issue(8'h35, 8'h35, 1'b0, 1'b1, 1'b1); wait_drain();
        issue(8'h35, 8'h35, 1'b1, 1'b0, 1'b1); wait_drain();
        issue(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1); wait_drain();
        issue(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1); wait_drain();
        issue(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1); wait_drain();
        issue(8'h00, 8'hFF, 1'b1, 1'b1, 1'b1); wait_drain();
        issue(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1); wait_drain();
        issue(8'h7F, 8'h80, 1'b0, 1'b1, 1'b1); wait_drain();
        issue(8'h7F, 8'h80, 1'b1, 1'b1, 1'b1); wait_drain();

        // Backpressure with a second request held during RUN/DONE.
        OUT_READY = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        IN_A     = 8'hC3;
        IN_B     = 8'h3C;
        IN_LT    = 1'b0;
        IN_VALID = 1'b1;
        n = 0;
        while (!OUT_VALID && n < 50) begin
            wait_cycle();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid_held", 64'(OUT_VALID), 64'(1));
            chk("bp_result_held", 64'(RESULT), 64'(1));
            chk("bp_in_ready_low", 64'(IN_READY), 64'(0));
            wait_cycle();
        end
        OUT_READY = 1'b1;
        wait_cycle();
        chk("bp_back_to_idle", 64'(IN_READY), 64'(1));
        chk("bp_out_valid_drop", 64'(OUT_VALID), 64'(0));
        sb.push_back(1'b0);
        wait_cycle();
        chk("bp_held_accepted", 64'(IN_READY), 64'(0));
        IN_VALID = 1'b0;
        wait_drain();

        // Reset on RUN cycle 2 discards the compare.
        issue(8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0);
        wait_cycle();
        RST = 1'b1;
        sb.delete();
        wait_cycle();
        RST = 1'b0;
        chk("midrst_in_ready", 64'(IN_READY), 64'(1));
        chk("midrst_out_valid", 64'(OUT_VALID), 64'(0));
        chk("midrst_slice", 64'({SA1, SA0, SB1, SB0, SCI}), 64'(0));
        repeat (8) wait_cycle();
        chk("midrst_no_result", 64'(OUT_VALID), 64'(0));
        issue(8'h10, 8'h10, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // Random regression with consumer stalls.
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rl = 1'($urandom_range(0, 1));
            issue(ra, rb, rl, rl ? (ra < rb) : (ra <= rb), 1'b0);
        end
        wait_drain();
        rand_stall = 1'b0;
        wait_cycle();
        OUT_READY = 1'b1;
        wait_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
